fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the 5-stage RV32I core: owns the PC register, issues instruction-memory requests over a valid/ready request channel with a separate response channel, and drives the IF/ID pipeline register. It consumes the stall, flush and redirect controls produced by the hazard unit and the execute stage. It buffers one returned instruction when decode is stalled, so no fetched instruction is lost or duplicated.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) loaded into IF/ID on flush/bubble
- clk_i  in  1  core clock
- rst_i  in  1  reset, asynchronous, active-high
- stall_fetch_i  in  1  hazard unit: hold PC, issue no new request
- stall_decode_i  in  1  hazard unit: hold IF/ID contents
- flush_decode_i  in  1  hazard unit: replace IF/ID with bubble
- pc_src_ex_i  in  1  execute: taken branch/jump redirect
- pc_target_ex_i  in  32  execute: redirect target
- imem_req_valid_o  out  1  request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  request address (word-aligned)
- imem_rsp_valid_i  in  1  response valid (never back-pressured)
- imem_rsp_data_i  in  32  instruction word
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_instr_o  out  32  IF/ID instruction
- if_id_pc_o  out  32  IF/ID PC
- if_id_pc_plus4_o  out  32  IF/ID PC+4

## Operation
- At most one request outstanding. Memory returns exactly one response per accepted request, at least 1 cycle after acceptance.
- Registers:
  - pc_q: next address to request.
  - pend_pc_q: PC of the outstanding request.
  - hold buffer: hold_valid_q, hold_instr_q, hold_pc_q.
  - state.
- States:
  - S_REQ: nothing outstanding.
  - S_WAIT: one live request outstanding.
  - S_DROP: one stale request outstanding; its response is discarded.
- imem_req_valid_o = !stall_fetch_i && !pc_src_ex_i && !hold_valid_q && (state==S_REQ || (state==S_WAIT && imem_rsp_valid_i && !stall_decode_i)).
- imem_req_addr_o = pc_q.
- On request handshake: pend_pc_q <= pc_q, pc_q <= pc_q+4 (mod 2^32 wrap), state <= S_WAIT.
- Response in S_WAIT, no redirect:
  - Delivered to IF/ID if !stall_decode_i.
  - Otherwise written to the hold buffer.
  - State becomes S_REQ unless a new request handshakes in the same cycle.
- Response in S_DROP: discarded; state <= S_REQ.
- Redirect (pc_src_ex_i=1):
  - pc_q <= pc_target_ex_i and hold_valid_q <= 0.
  - S_WAIT without a response that cycle -> S_DROP.
  - S_WAIT with a response that cycle -> response discarded, S_REQ.
  - S_DROP stays S_DROP unless its response arrives that cycle.
  - No request issued in the redirect cycle.
- IF/ID update priority:
  1. flush_decode_i: valid=0, instr=NOP_INSTR, pc/pc_plus4 hold.
  2. stall_decode_i: hold.
  3. hold_valid_q: load from hold buffer and clear it.
  4. Live response: load it.
  5. Otherwise bubble (valid=0, NOP_INSTR).
- The hold buffer and a live response are never valid together, because requests are blocked while hold_valid_q=1.
- if_id_pc_plus4_o = if_id_pc_o + 4, computed at load time.

## Timing
- Reset values (asynchronous):
  - pc_q=RESET_PC, state=S_REQ, hold_valid_q=0.
  - if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc_plus4_o=0.
  - imem_req_valid_o=1 in the first cycle after reset deassertion (all control inputs low).
- Latency: fetch-to-IF/ID = memory latency cycles after the request handshake; the instruction is visible the cycle after the response.
- Throughput: 1 instruction/cycle with a 1-cycle memory and ready always high.
- imem_req_valid_o and imem_req_addr_o stay stable while valid && !ready, unless pc_src_ex_i or stall_fetch_i withdraws the request. Withdrawal is permitted; the memory handshakes only when both valid and ready are high.
- Reset mid-transaction: the outstanding request is forgotten and the memory side is also reset. No response is expected after reset.

## Test plan
- Reset, memory with 1-cycle latency and ready=1, returning addr^32'hA5A5_0000 -> requests at 0,4,8,…; from cycle 2, if_id_pc_o advances by 4 every cycle with valid=1.
- stall_fetch_i=stall_decode_i=1 for 3 cycles while response for PC 0x8 arrives -> it is held in the buffer; IF/ID keeps PC 0x4; after release, IF/ID=0x8, then 0xC; no duplicate or skipped PC.
- Redirect to 0x100 while request 0x10 is outstanding (4-cycle latency) -> response for 0x10 is dropped, next request is 0x100, IF/ID never shows 0x10.
- Redirect in the same cycle as the response and flush_decode_i=1 -> IF/ID=bubble (valid=0, 0x00000013), next request 0x100.
- imem_req_ready_i low for 5 cycles -> addr stays constant, IF/ID bubbles, then resumes in order.
- pc_q=0xFFFF_FFFC -> next request address 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem request/response channels and
// the IF/ID pipeline register, with a one-entry hold buffer for decode stalls.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_fetch_i,
    input  logic        stall_decode_i,
    input  logic        flush_decode_i,
    input  logic        pc_src_ex_i,
    input  logic [31:0] pc_target_ex_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_hold_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_if_id_valid;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_pc4;

    logic w_rsp_wait;
    logic w_live;
    logic w_req_valid;
    logic w_fire;

    assign w_rsp_wait  = (r_state == S_WAIT) && imem_rsp_valid_i;
    assign w_live      = w_rsp_wait && !pc_src_ex_i;
    // Back-to-back issue is allowed only when the returning word leaves now.
    assign w_req_valid = !stall_fetch_i && !pc_src_ex_i && !r_hold_valid &&
                         ((r_state == S_REQ) ||
                          (w_rsp_wait && !stall_decode_i));
    assign w_fire      = w_req_valid && imem_req_ready_i;

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_pc;
    assign if_id_valid_o    = r_if_id_valid;
    assign if_id_instr_o    = r_if_id_instr;
    assign if_id_pc_o       = r_if_id_pc;
    assign if_id_pc_plus4_o = r_if_id_pc4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_hold_valid <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_hold_pc    <= RESET_PC;
        end else if (pc_src_ex_i) begin
            r_pc         <= pc_target_ex_i;
            r_hold_valid <= 1'b0;
            unique case (r_state)
                S_WAIT:  r_state <= imem_rsp_valid_i ? S_REQ : S_DROP;
                S_DROP:  r_state <= imem_rsp_valid_i ? S_REQ : S_DROP;
                default: r_state <= S_REQ;
            endcase
        end else begin
            if (w_fire) begin
                r_pend_pc <= r_pc;
                r_pc      <= r_pc + 32'd4;
                r_state   <= S_WAIT;
            end else if (imem_rsp_valid_i && r_state != S_REQ) begin
                r_state <= S_REQ;
            end
            if (w_live && stall_decode_i) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= imem_rsp_data_i;
                r_hold_pc    <= r_pend_pc;
            end else if (r_hold_valid && !stall_decode_i && !flush_decode_i) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= 32'd0;
            r_if_id_pc4   <= 32'd0;
        end else if (flush_decode_i) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
        end else if (!stall_decode_i) begin
            if (r_hold_valid) begin
                r_if_id_valid <= 1'b1;
                r_if_id_instr <= r_hold_instr;
                r_if_id_pc    <= r_hold_pc;
                r_if_id_pc4   <= r_hold_pc + 32'd4;
            end else if (w_live) begin
                r_if_id_valid <= 1'b1;
                r_if_id_instr <= imem_rsp_data_i;
                r_if_id_pc    <= r_pend_pc;
                r_if_id_pc4   <= r_pend_pc + 32'd4;
            end else begin
                r_if_id_valid <= 1'b0;
                r_if_id_instr <= NOP_INSTR;
            end
        end
    end

endmodule
